// File: rtl/mem_writeback_stage.sv
// MEM/WB pipeline register and writeback logic for the RV32I core: load extraction, source select,
// x0/fault write suppression and forwarding mirror. Optional retire counter under RETIRE_COUNTER_EN.
module mem_writeback_stage #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            nReset,
   input  logic            stall,
   input  logic            flush,
   input  logic            memValid,
   input  logic            memRegWrite,
   input  logic [4:0]      memRd,
   input  logic [1:0]      memResultSel,
   input  logic [XLEN-1:0] memAluResult,
   input  logic [XLEN-1:0] memLoadData,
   input  logic [2:0]      memLoadFunct3,
   input  logic            memIsLoad,
   input  logic [XLEN-1:0] memPcPlus4,
   output logic [4:0]      writeRegisterIndex,
   output logic [XLEN-1:0] writeRegisterData,
   output logic            shouldWrite,
   output logic            forwardValid,
   output logic [4:0]      forwardIndex,
   output logic [XLEN-1:0] forwardData,
`ifdef RETIRE_COUNTER_EN
   output logic [63:0]     retireCount,
`endif
   output logic            loadFault
);

   logic            wbValid;
   logic            wbRegWrite;
   logic [4:0]      wbRd;
   logic [1:0]      wbResultSel;
   logic [XLEN-1:0] wbAluResult;
   logic [XLEN-1:0] wbLoadValue;
   logic            wbFault;
   logic [XLEN-1:0] wbPcPlus4;

   logic [7:0]      loadByte;
   logic [15:0]     loadHalf;
   logic [XLEN-1:0] extValue;
   logic            extFault;
   logic            capFault;
   logic [XLEN-1:0] selData;
   logic            writeEnable;

   // Extract and extend the addressed byte/halfword/word; misaligned or unknown widths fault with value 0.
   always_comb begin
      loadByte = 8'd0;
      loadHalf = 16'd0;
      extValue = {XLEN{1'b0}};
      extFault = 1'b0;
      case (memAluResult[1:0])
         2'd0:    loadByte = memLoadData[7:0];
         2'd1:    loadByte = memLoadData[15:8];
         2'd2:    loadByte = memLoadData[23:16];
         2'd3:    loadByte = memLoadData[31:24];
         default: loadByte = memLoadData[7:0];
      endcase
      if (memAluResult[1]) begin
         loadHalf = memLoadData[31:16];
      end else begin
         loadHalf = memLoadData[15:0];
      end
      case (memLoadFunct3)
         3'b000: extValue = {{(XLEN-8){loadByte[7]}}, loadByte};
         3'b100: extValue = {{(XLEN-8){1'b0}}, loadByte};
         3'b001: begin
            if (memAluResult[0]) begin
               extFault = 1'b1;
            end else begin
               extValue = {{(XLEN-16){loadHalf[15]}}, loadHalf};
            end
         end
         3'b101: begin
            if (memAluResult[0]) begin
               extFault = 1'b1;
            end else begin
               extValue = {{(XLEN-16){1'b0}}, loadHalf};
            end
         end
         3'b010: begin
            if (memAluResult[1:0] != 2'd0) begin
               extFault = 1'b1;
            end else begin
               extValue = memLoadData;
            end
         end
         default: extFault = 1'b1;
      endcase
   end

   // Only real loads can fault; non-load instructions carry an arbitrary funct3.
   assign capFault = extFault & memIsLoad;

   // WB pipeline register: flush outranks stall, stall holds every field.
   always_ff @(posedge clk or negedge nReset) begin
      if (!nReset) begin
         wbValid     <= 1'b0;
         wbRegWrite  <= 1'b0;
         wbRd        <= 5'd0;
         wbResultSel <= 2'd0;
         wbAluResult <= {XLEN{1'b0}};
         wbLoadValue <= {XLEN{1'b0}};
         wbFault     <= 1'b0;
         wbPcPlus4   <= {XLEN{1'b0}};
      end else if (flush) begin
         wbValid <= 1'b0;
      end else if (!stall) begin
         wbValid     <= memValid;
         wbRegWrite  <= memRegWrite;
         wbRd        <= memRd;
         wbResultSel <= memResultSel;
         wbAluResult <= memAluResult;
         wbLoadValue <= extValue;
         wbFault     <= capFault;
         wbPcPlus4   <= memPcPlus4;
      end else begin
         wbValid <= wbValid;
      end
   end

   // Writeback source select; the reserved encoding falls back to the ALU result.
   always_comb begin
      selData = wbAluResult;
      case (wbResultSel)
         2'd0:    selData = wbAluResult;
         2'd1:    selData = wbLoadValue;
         2'd2:    selData = wbPcPlus4;
         default: selData = wbAluResult;
      endcase
   end

   assign loadFault          = wbValid & wbFault;
   assign writeEnable        = wbValid & wbRegWrite & (wbRd != 5'd0) & ~(wbValid & wbFault);
   assign shouldWrite        = writeEnable;
   assign writeRegisterIndex = wbRd;
   assign writeRegisterData  = selData;
   assign forwardValid       = writeEnable;
   assign forwardIndex       = wbRd;
   assign forwardData        = selData;

`ifdef RETIRE_COUNTER_EN
   logic [63:0] retireCnt;

   // Count valid, non-faulting instructions leaving WB (advanced or flushed out).
   always_ff @(posedge clk or negedge nReset) begin
      if (!nReset) begin
         retireCnt <= 64'd0;
      end else if (wbValid && !wbFault && (!stall || flush)) begin
         retireCnt <= retireCnt + 64'd1;
      end else begin
         retireCnt <= retireCnt;
      end
   end

   assign retireCount = retireCnt;
`endif

endmodule

// File: tb/tb_mem_writeback_stage.sv
// Self-checking bench for mem_writeback_stage: directed vectors with literal expectations plus
// a per-cycle comparison against a behavioural model of the WB stage.
module tb_mem_writeback_stage;

   logic        clk = 1'b0;
   logic        nReset;
   logic        stall, flush;
   logic        memValid, memRegWrite, memIsLoad;
   logic [4:0]  memRd;
   logic [1:0]  memResultSel;
   logic [31:0] memAluResult, memLoadData, memPcPlus4;
   logic [2:0]  memLoadFunct3;
   logic [4:0]  writeRegisterIndex, forwardIndex;
   logic [31:0] writeRegisterData, forwardData;
   logic        shouldWrite, forwardValid, loadFault;
`ifdef RETIRE_COUNTER_EN
   logic [63:0] retireCount;
`endif

   int vectors = 0;
   int miscompares = 0;

   mem_writeback_stage #(.XLEN(32)) dut (
      .clk(clk), .nReset(nReset), .stall(stall), .flush(flush),
      .memValid(memValid), .memRegWrite(memRegWrite), .memRd(memRd),
      .memResultSel(memResultSel), .memAluResult(memAluResult),
      .memLoadData(memLoadData), .memLoadFunct3(memLoadFunct3),
      .memIsLoad(memIsLoad), .memPcPlus4(memPcPlus4),
      .writeRegisterIndex(writeRegisterIndex), .writeRegisterData(writeRegisterData),
      .shouldWrite(shouldWrite), .forwardValid(forwardValid),
      .forwardIndex(forwardIndex), .forwardData(forwardData),
`ifdef RETIRE_COUNTER_EN
      .retireCount(retireCount),
`endif
      .loadFault(loadFault)
   );

   always #5 clk = ~clk;

   task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Load semantics written as plain arithmetic on the shifted word.
   function automatic logic [31:0] modelLoad(input logic [31:0] word, input logic [31:0] addr,
                                              input logic [2:0] f3, output logic fault);
      logic [31:0] b, h;
      b = (word >> (8 * addr[1:0])) & 32'hFF;
      h = (word >> (8 * addr[1:0])) & 32'hFFFF;
      fault = 1'b0;
      modelLoad = 32'd0;
      case (f3)
         3'b000: modelLoad = (b >= 32'd128) ? b - 32'd256 : b;
         3'b100: modelLoad = b;
         3'b001: if (addr[0]) fault = 1'b1; else modelLoad = (h >= 32'd32768) ? h - 32'd65536 : h;
         3'b101: if (addr[0]) fault = 1'b1; else modelLoad = h;
         3'b010: if (addr[1:0] != 2'd0) fault = 1'b1; else modelLoad = word;
         default: fault = 1'b1;
      endcase
   endfunction

   // Model: the instruction currently in WB, stored as its raw memory-stage inputs.
   logic        mValid, mRegWrite, mIsLoad;
   logic [4:0]  mRd;
   logic [1:0]  mSel;
   logic [31:0] mAlu, mData, mPc;
   logic [2:0]  mF3;
   logic [63:0] mRetire;
   logic        mRawFault;
   logic [31:0] mLoadVal;

   always @(posedge clk or negedge nReset) begin
      if (!nReset) begin
         mValid <= 1'b0; mRegWrite <= 1'b0; mIsLoad <= 1'b0; mRd <= 5'd0; mSel <= 2'd0;
         mAlu <= 32'd0; mData <= 32'd0; mPc <= 32'd0; mF3 <= 3'd0; mRetire <= 64'd0;
      end else begin
         logic f;
         logic [31:0] v;
         v = modelLoad(mData, mAlu, mF3, f);
         if (mValid && !(f && mIsLoad) && (!stall || flush)) mRetire <= mRetire + 64'd1;
         if (flush) mValid <= 1'b0;
         else if (!stall) begin
            mValid <= memValid; mRegWrite <= memRegWrite; mIsLoad <= memIsLoad; mRd <= memRd;
            mSel <= memResultSel; mAlu <= memAluResult; mData <= memLoadData;
            mPc <= memPcPlus4; mF3 <= memLoadFunct3;
         end
      end
   end

   // Compare every output against the model on each falling edge.
   always @(negedge clk) begin
      logic [31:0] eData;
      logic        eFault, eWrite;
      mLoadVal = modelLoad(mData, mAlu, mF3, mRawFault);
      eFault = mValid && mIsLoad && mRawFault;
      eData = (mSel == 2'd1) ? (mRawFault ? 32'd0 : mLoadVal) : (mSel == 2'd2) ? mPc : mAlu;
      eWrite = mValid && mRegWrite && (mRd != 5'd0) && !eFault;
      cmp("m_loadFault", {63'd0, loadFault}, {63'd0, eFault});
      cmp("m_shouldWrite", {63'd0, shouldWrite}, {63'd0, eWrite});
      cmp("m_forwardValid", {63'd0, forwardValid}, {63'd0, eWrite});
      cmp("m_index", {59'd0, writeRegisterIndex}, {59'd0, mRd});
      cmp("m_fwdIndex", {59'd0, forwardIndex}, {59'd0, mRd});
      cmp("m_data", {32'd0, writeRegisterData}, {32'd0, eData});
      cmp("m_fwdData", {32'd0, forwardData}, {32'd0, eData});
`ifdef RETIRE_COUNTER_EN
      cmp("m_retire", retireCount, mRetire);
`endif
   end

   task automatic issue(input logic v, input logic rw, input logic [4:0] rd, input logic [1:0] sel,
                        input logic [31:0] alu, input logic [31:0] ld, input logic [2:0] f3,
                        input logic isl, input logic [31:0] pc);
      memValid = v; memRegWrite = rw; memRd = rd; memResultSel = sel; memAluResult = alu;
      memLoadData = ld; memLoadFunct3 = f3; memIsLoad = isl; memPcPlus4 = pc;
      @(posedge clk);
      #2;
   endtask

   task automatic chk(input string name, input logic sw, input logic [4:0] idx,
                      input logic [31:0] data, input logic flt);
      cmp({name, "_sw"}, {63'd0, shouldWrite}, {63'd0, sw});
      cmp({name, "_idx"}, {59'd0, writeRegisterIndex}, {59'd0, idx});
      cmp({name, "_data"}, {32'd0, writeRegisterData}, {32'd0, data});
      cmp({name, "_fault"}, {63'd0, loadFault}, {63'd0, flt});
   endtask

   localparam logic [31:0] LDW = 32'h80FF7F01;

   initial begin
      nReset = 1'b0; stall = 1'b0; flush = 1'b0;
      memValid = 1'b0; memRegWrite = 1'b0; memRd = 5'd0; memResultSel = 2'd0;
      memAluResult = 32'd0; memLoadData = 32'd0; memLoadFunct3 = 3'd0; memIsLoad = 1'b0;
      memPcPlus4 = 32'd0;
      for (int i = 0; i < 4; i++) begin
         issue(i[0] == 1'b0, 1'b1, 5'd3, 2'd0, 32'h1111, 32'd0, 3'd0, 1'b0, 32'd4);
         chk("reset_hold", 1'b0, 5'd0, 32'd0, 1'b0);
      end
      nReset = 1'b1;
      issue(1'b1, 1'b1, 5'd3, 2'd1, 32'h1003, LDW, 3'b000, 1'b1, 32'd8);
      chk("lb", 1'b1, 5'd3, 32'hFFFFFF80, 1'b0);
      issue(1'b1, 1'b1, 5'd4, 2'd1, 32'h1003, LDW, 3'b100, 1'b1, 32'd8);
      chk("lbu", 1'b1, 5'd4, 32'h00000080, 1'b0);
      issue(1'b1, 1'b1, 5'd6, 2'd1, 32'h1002, LDW, 3'b001, 1'b1, 32'd8);
      chk("lh", 1'b1, 5'd6, 32'hFFFF80FF, 1'b0);
      issue(1'b1, 1'b1, 5'd6, 2'd1, 32'h1002, LDW, 3'b101, 1'b1, 32'd8);
      chk("lhu", 1'b1, 5'd6, 32'h000080FF, 1'b0);
      issue(1'b1, 1'b1, 5'd6, 2'd1, 32'h1002, LDW, 3'b010, 1'b1, 32'd8);
      chk("lw_misaligned", 1'b0, 5'd6, 32'd0, 1'b1);
      issue(1'b1, 1'b1, 5'd2, 2'd1, 32'h1001, LDW, 3'b001, 1'b1, 32'd8);
      chk("lh_misaligned", 1'b0, 5'd2, 32'd0, 1'b1);
      issue(1'b1, 1'b1, 5'd2, 2'd1, 32'h1000, LDW, 3'b010, 1'b1, 32'd8);
      chk("lw", 1'b1, 5'd2, LDW, 1'b0);
      issue(1'b1, 1'b1, 5'd2, 2'd1, 32'h1000, LDW, 3'b011, 1'b1, 32'd8);
      chk("illegal_f3", 1'b0, 5'd2, 32'd0, 1'b1);
      issue(1'b1, 1'b1, 5'd5, 2'd0, 32'h12345678, LDW, 3'b111, 1'b0, 32'd8);
      chk("alu", 1'b1, 5'd5, 32'h12345678, 1'b0);
      issue(1'b1, 1'b1, 5'd5, 2'd2, 32'h12345678, LDW, 3'b000, 1'b0, 32'h104);
      chk("pc4", 1'b1, 5'd5, 32'h00000104, 1'b0);
      issue(1'b1, 1'b1, 5'd0, 2'd0, 32'h0000DEAD, LDW, 3'b000, 1'b0, 32'h104);
      chk("rd0", 1'b0, 5'd0, 32'h0000DEAD, 1'b0);
      issue(1'b1, 1'b1, 5'd8, 2'd3, 32'h00000055, LDW, 3'b000, 1'b0, 32'h104);
      chk("sel3", 1'b1, 5'd8, 32'h00000055, 1'b0);
      issue(1'b0, 1'b1, 5'd8, 2'd0, 32'h00000066, LDW, 3'b000, 1'b0, 32'h104);
      chk("bubble", 1'b0, 5'd8, 32'h00000066, 1'b0);
      issue(1'b1, 1'b1, 5'd7, 2'd0, 32'h000000AA, LDW, 3'b000, 1'b0, 32'h104);
      chk("pre_stall", 1'b1, 5'd7, 32'h000000AA, 1'b0);
      stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         issue(1'b1, 1'b1, 5'd9, 2'd0, 32'h000000BB + i, LDW, 3'b000, 1'b0, 32'h200);
         chk("stall_hold", 1'b1, 5'd7, 32'h000000AA, 1'b0);
      end
      flush = 1'b1;
      issue(1'b1, 1'b1, 5'd9, 2'd0, 32'h000000CC, LDW, 3'b000, 1'b0, 32'h200);
      chk("stall_flush", 1'b0, 5'd7, 32'h000000AA, 1'b0);
      stall = 1'b0; flush = 1'b0;
      issue(1'b1, 1'b1, 5'd10, 2'd0, 32'h00000077, LDW, 3'b000, 1'b0, 32'h200);
      chk("pre_reset", 1'b1, 5'd10, 32'h00000077, 1'b0);
      #1 nReset = 1'b0;
      #1 chk("async_reset", 1'b0, 5'd0, 32'd0, 1'b0);
      cmp("async_fwd", {63'd0, forwardValid}, 64'd0);
      @(posedge clk);
      #2 nReset = 1'b1;
      issue(1'b1, 1'b1, 5'd11, 2'd0, 32'h00000099, LDW, 3'b000, 1'b0, 32'h200);
      chk("post_reset", 1'b1, 5'd11, 32'h00000099, 1'b0);
      issue(1'b0, 1'b0, 5'd0, 2'd0, 32'd0, 32'd0, 3'd0, 1'b0, 32'd0);
      issue(1'b0, 1'b0, 5'd0, 2'd0, 32'd0, 32'd0, 3'd0, 1'b0, 32'd0);
      @(negedge clk);
      #1;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
